// File: rtl/dmem_arb_pkg.sv
// Shared types and encodings for the data-memory port arbiter.
// Owner encoding plus the MemWrite/READMODE idle values seen by the Memory instance.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_CPU = 2'd1,
    OWN_LDR = 2'd2
  } owner_t;

  localparam logic [1:0] MEMWE_NONE = 2'b00;
  localparam logic [2:0] RM_WORD    = 3'd0;

endpackage

// File: rtl/dmem_req_mux.sv
// Steers the granted requester's fields onto the memory port; combinational, no backpressure.
// With no grant the port is parked: no write, all other fields zero.
module dmem_req_mux
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              cpu_gnt,
  input  logic [1:0]        cpu_we,
  input  logic [2:0]        cpu_rmode,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              ldr_gnt,
  input  logic [1:0]        ldr_we,
  input  logic [2:0]        ldr_rmode,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic [1:0]        mem_we,
  output logic [2:0]        mem_rmode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd
);

  always_comb begin
    mem_we    = MEMWE_NONE;
    mem_rmode = RM_WORD;
    mem_addr  = '0;
    mem_wd    = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_rmode = cpu_rmode;
      mem_addr  = cpu_addr;
      mem_wd    = cpu_wdata;
    end else if (ldr_gnt) begin
      mem_we    = ldr_we;
      mem_rmode = ldr_rmode;
      mem_addr  = ldr_addr;
      mem_wd    = ldr_wdata;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Registered req/gnt arbiter sharing one data-memory port between CPU and UART loader; 1-cycle grant latency.
// Loader wins ties but yields after MAX_HOLD grants; cpu_stall freezes the PC while waiting. ARB_STATS_EN adds stall_count.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [1:0]        cpu_we,
  input  logic [2:0]        cpu_rmode,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ldr_req,
  input  logic [1:0]        ldr_we,
  input  logic [2:0]        ldr_rmode,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic [1:0]        mem_we,
  output logic [2:0]        mem_rmode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]       stall_count
`endif
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  owner_t            owner, owner_nxt;
  logic [HOLD_W-1:0] hold_cnt;

  // Grants are combinational on the registered owner so an async reset drops them at once.
  assign cpu_gnt   = (owner == OWN_CPU) && cpu_req;
  assign ldr_gnt   = (owner == OWN_LDR) && ldr_req;
  assign cpu_stall = cpu_req && !cpu_gnt;
  assign cpu_rdata = mem_rd;
  assign ldr_rdata = mem_rd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) owner <= IDLE;
    else        owner <= owner_nxt;
  end

  always_comb begin
    owner_nxt = IDLE;
    if (cpu_req && ldr_req) begin
      if (owner == OWN_LDR && hold_cnt == HOLD_LAST) owner_nxt = OWN_CPU;
      else                                           owner_nxt = OWN_LDR;
    end else if (cpu_req) begin
      owner_nxt = OWN_CPU;
    end else if (ldr_req) begin
      owner_nxt = OWN_LDR;
    end
  end

  // Counts loader grants that the waiting CPU has had to sit through.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                             hold_cnt <= '0;
    else if (!cpu_req || cpu_gnt)           hold_cnt <= '0;
    else if (ldr_gnt && hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + 1'b1;
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                stall_count <= '0;
    else if (cpu_stall && stall_count != '1)   stall_count <= stall_count + 32'd1;
  end
`endif

  dmem_req_mux #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mux (
    .cpu_gnt  (cpu_gnt),
    .cpu_we   (cpu_we),
    .cpu_rmode(cpu_rmode),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .ldr_gnt  (ldr_gnt),
    .ldr_we   (ldr_we),
    .ldr_rmode(ldr_rmode),
    .ldr_addr (ldr_addr),
    .ldr_wdata(ldr_wdata),
    .mem_we   (mem_we),
    .mem_rmode(mem_rmode),
    .mem_addr (mem_addr),
    .mem_wd   (mem_wd)
  );

  // Requesters must hold req until granted.
  a_cpu_hold: assert property (@(posedge clk) disable iff (!reset)
    (cpu_req && !cpu_gnt) |=> cpu_req);
  a_ldr_hold: assert property (@(posedge clk) disable iff (!reset)
    (ldr_req && !ldr_gnt) |=> ldr_req);

endmodule
